// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC frame loader and its RAM.
package crc_pkg;

  localparam int CRC_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SHORT    = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } frame_err_t;

endpackage

// File: rtl/crc_frame_loader_if.sv
// Stream, checker read port and result signals of the frame loader.
interface crc_frame_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [15:0]       crc_out_target;
  logic [ADDR_W:0]   msg_len;
  logic              crc_start;
  logic              crc_rdy;
  logic              crc_ok;
  logic              frame_done;
  logic              frame_ok;
  logic [1:0]        err;

  modport slave (
    input  in_data, in_valid, in_last, mem_addr, crc_rdy, crc_ok,
    output in_ready, mem_data, crc_out_target, msg_len, crc_start,
           frame_done, frame_ok, err
  );

  modport master (
    output in_data, in_valid, in_last, mem_addr, crc_rdy, crc_ok,
    input  in_ready, mem_data, crc_out_target, msg_len, crc_start,
           frame_done, frame_ok, err
  );
endinterface

// File: rtl/crc_msg_ram.sv
// Simple dual-port message RAM: synchronous write, registered read.
module crc_msg_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [2**ADDR_W];

  // NOTE: the storage array is never reset so it maps onto block RAM;
  // only the read output register carries a reset value.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/crc_frame_loader.sv
// Loads a payload+CRC16 frame into message RAM, launches the checker and
// reports a per-frame result.
module crc_frame_loader
  import crc_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                 clk50m,
  input logic                 rst,
  crc_frame_loader_if.slave   bus
);

  localparam int              DEPTH = 2**ADDR_W;
  localparam int              CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

  loader_state_t   state, next_state;
  logic [7:0]      hold_old, hold_new;
  logic [1:0]      hold_cnt;
  logic [ADDR_W:0] wr_ptr, len_next;
  logic [CNT_W-1:0] wait_cnt;
  logic            rdy_q, rise_q;
  logic [15:0]     target_q;
  logic [ADDR_W:0] len_q;
  frame_err_t      err_q, done_err;
  logic            ok_q, done_ok;
  logic            accept, hold_full, wr_en, shift_in, capture;
  logic [7:0]      rd_data;

  assign hold_full = (hold_cnt == 2'(CRC_BYTES));
  assign accept    = bus.in_valid & bus.in_ready;
  // Payload length once this byte lands: a full hold register forces a write.
  assign len_next  = wr_ptr + (ADDR_W+1)'(hold_full);

  assign bus.in_ready       = ~rst & (state inside {ST_IDLE, ST_LOAD, ST_DRAIN});
  assign bus.crc_start      = (state == ST_START);
  assign bus.frame_done     = (state == ST_DONE);
  assign bus.crc_out_target = target_q;
  assign bus.msg_len        = len_q;
  assign bus.frame_ok       = ok_q;
  assign bus.err            = err_q;
  assign bus.mem_data       = rd_data;

  // NOTE: every output of this block gets a default first so no path
  // through the case statement leaves a latch behind.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    shift_in   = 1'b0;
    capture    = 1'b0;
    done_err   = ERR_NONE;
    done_ok    = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) begin
        shift_in = 1'b1;
        if (bus.in_last) begin
          next_state = ST_DONE;
          done_err   = ERR_SHORT;
        end else begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: if (accept) begin
        if (hold_full && wr_ptr == FULL) begin
          done_err   = ERR_OVERFLOW;
          next_state = bus.in_last ? ST_DONE : ST_DRAIN;
        end else begin
          wr_en    = hold_full;
          shift_in = 1'b1;
          if (bus.in_last) begin
            capture = 1'b1;
            if (len_next == '0) begin
              next_state = ST_DONE;
              done_err   = ERR_SHORT;
            end else begin
              next_state = ST_START;
            end
          end
        end
      end
      ST_DRAIN: if (accept && bus.in_last) begin
        next_state = ST_DONE;
        done_err   = ERR_OVERFLOW;
      end
      ST_START: next_state = ST_WAIT;
      ST_WAIT: begin
        // A fresh checker rise beats a timeout landing on the same cycle.
        if (rise_q) begin
          next_state = ST_CHECK;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          next_state = ST_DONE;
          done_err   = ERR_TIMEOUT;
        end
      end
      ST_CHECK: begin
        next_state = ST_DONE;
        done_ok    = bus.crc_ok;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // here samples the pre-edge values of the others.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_old <= '0;
      hold_new <= '0;
      hold_cnt <= '0;
      wr_ptr   <= '0;
      wait_cnt <= '0;
      rdy_q    <= 1'b0;
      rise_q   <= 1'b0;
      target_q <= '0;
      len_q    <= '0;
      err_q    <= ERR_NONE;
      ok_q     <= 1'b0;
    end else begin
      state  <= next_state;
      rdy_q  <= bus.crc_rdy;
      rise_q <= bus.crc_rdy & ~rdy_q;

      if (shift_in) begin
        hold_old <= hold_new;
        hold_new <= bus.in_data;
        if (!hold_full) hold_cnt <= hold_cnt + 2'd1;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;

      if (capture) begin
        target_q <= {bus.in_data, hold_new};
        len_q    <= len_next;
      end

      if (state == ST_START)     wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (state == ST_DONE) begin
        hold_cnt <= '0;
        hold_old <= '0;
        hold_new <= '0;
        wr_ptr   <= '0;
      end

      if (next_state == ST_DONE) begin
        err_q <= done_err;
        ok_q  <= done_ok;
      end
    end
  end

  crc_msg_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk50m),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (hold_old),
    .rd_addr (bus.mem_addr),
    .rd_data (rd_data)
  );

endmodule
